// File: rtl/aes_decipher_ctrl.sv
// Round sequencer for the AES decipher datapath: INIT, N-1 MAIN rounds, FINAL, for AES-128/256.
// Defining AES_DECIPHER_CTRL_ABORT_EN adds an abort input that cancels a running block.
module aes_decipher_ctrl #(
    parameter int NUM_ROUNDS_128 = 10,
    parameter int NUM_ROUNDS_256 = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
`ifdef AES_DECIPHER_CTRL_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] block,
    input  logic [127:0] round_key,
    input  logic [127:0] round_new_block,
    output logic [127:0] round_block,
    output logic [3:0]   round_key_addr,
    output logic [1:0]   round_type,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         valid
);

    localparam logic [3:0] ROUNDS_128 = 4'(NUM_ROUNDS_128);
    localparam logic [3:0] ROUNDS_256 = 4'(NUM_ROUNDS_256);
    localparam logic [1:0] RT_INIT    = 2'd0;
    localparam logic [1:0] RT_MAIN    = 2'd1;
    localparam logic [1:0] RT_FINAL   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_MAIN  = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    function automatic logic parity128(input logic [127:0] v);
        return ^v;
    endfunction

    state_t         state_r, state_nxt_s;
    logic [127:0]   block_r, block_nxt_s;
    logic [3:0]     cnt_r, cnt_nxt_s;
    logic           keylen_r, keylen_nxt_s;
    logic           ready_r, ready_nxt_s;
    logic           valid_r, valid_nxt_s;
    logic [1:0]     rtype_r, rtype_nxt_s;
    logic [3:0]     raddr_r, raddr_nxt_s;
    logic           abort_s;
    logic           abort_hit_s;
    logic           unused_round_key_s;

    // The key only flows from memory into the datapath; the controller never inspects it.
    assign unused_round_key_s = parity128(round_key);

`ifdef AES_DECIPHER_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign abort_hit_s = abort_s && (state_r != ST_IDLE);

    // Next-state, counter and state-register update; abort overrides any round step.
    always_comb begin
        state_nxt_s  = state_r;
        block_nxt_s  = block_r;
        cnt_nxt_s    = cnt_r;
        keylen_nxt_s = keylen_r;
        ready_nxt_s  = ready_r;
        valid_nxt_s  = valid_r;
        if (abort_hit_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
            ready_nxt_s = 1'b1;
            valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (next) begin
                        block_nxt_s  = block;
                        keylen_nxt_s = keylen;
                        cnt_nxt_s    = keylen ? ROUNDS_256 : ROUNDS_128;
                        ready_nxt_s  = 1'b0;
                        valid_nxt_s  = 1'b0;
                        state_nxt_s  = ST_INIT;
                    end else begin
                        state_nxt_s  = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    block_nxt_s = round_new_block;
                    cnt_nxt_s   = cnt_r - 4'd1;
                    state_nxt_s = ST_MAIN;
                end
                ST_MAIN: begin
                    block_nxt_s = round_new_block;
                    cnt_nxt_s   = cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_nxt_s = ST_FINAL;
                    end else begin
                        state_nxt_s = ST_MAIN;
                    end
                end
                ST_FINAL: begin
                    block_nxt_s = round_new_block;
                    cnt_nxt_s   = 4'd0;
                    ready_nxt_s = 1'b1;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                    ready_nxt_s = 1'b1;
                    valid_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Round type and key address are decoded from the next state so they leave a flop glitch-free.
    always_comb begin
        rtype_nxt_s = RT_INIT;
        raddr_nxt_s = 4'd0;
        case (state_nxt_s)
            ST_INIT: begin
                rtype_nxt_s = RT_INIT;
                raddr_nxt_s = cnt_nxt_s;
            end
            ST_MAIN: begin
                rtype_nxt_s = RT_MAIN;
                raddr_nxt_s = cnt_nxt_s;
            end
            ST_FINAL: begin
                rtype_nxt_s = RT_FINAL;
                raddr_nxt_s = 4'd0;
            end
            default: begin
                rtype_nxt_s = RT_INIT;
                raddr_nxt_s = 4'd0;
            end
        endcase
    end

    // Controller state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            block_r  <= 128'd0;
            cnt_r    <= 4'd0;
            keylen_r <= 1'b0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            rtype_r  <= RT_INIT;
            raddr_r  <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            block_r  <= block_nxt_s;
            cnt_r    <= cnt_nxt_s;
            keylen_r <= keylen_nxt_s;
            ready_r  <= ready_nxt_s;
            valid_r  <= valid_nxt_s;
            rtype_r  <= rtype_nxt_s;
            raddr_r  <= raddr_nxt_s;
        end
    end

    assign round_block    = block_r;
    assign new_block      = block_r;
    assign round_type     = rtype_r;
    assign round_key_addr = raddr_r;
    assign ready          = ready_r;
    assign valid          = valid_r;

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl: transaction-level reference model plus an AES-128 inverse-cipher
// datapath/key-memory model; abort tests are built when AES_DECIPHER_CTRL_ABORT_EN is defined.
module tb_aes_decipher_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic         abort;
    logic [127:0] block;
    logic [127:0] round_key;
    logic [127:0] round_new_block;
    logic [127:0] round_block;
    logic [3:0]   round_key_addr;
    logic [1:0]   round_type;
    logic [127:0] new_block;
    logic         ready;
    logic         valid;
    logic         aes_mode;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    aes_decipher_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .next(next),
        .keylen(keylen),
`ifdef AES_DECIPHER_CTRL_ABORT_EN
        .abort(abort),
`endif
        .block(block),
        .round_key(round_key),
        .round_new_block(round_new_block),
        .round_block(round_block),
        .round_key_addr(round_key_addr),
        .round_type(round_type),
        .new_block(new_block),
        .ready(ready),
        .valid(valid)
    );

    // ---------------- AES arithmetic for the datapath / key memory model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01; p = a; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[0]) r = gmul(r, p);
            p = gmul(p, p);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] mcoef(input int j);
        case (j)
            0: return 8'h0e;
            1: return 8'h0b;
            2: return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // Round key "addr" of the AES-128 expansion of KEY (addresses past 10 keep expanding).
    function automatic logic [127:0] keymem(input logic [3:0] addr);
        logic [127:0] k;
        logic [31:0]  w[4];
        logic [31:0]  t;
        logic [7:0]   rc;
        k = KEY;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int r = 0; r < int'(addr); r++) begin
            t = {w[3][23:0], w[3][31:24]};
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'd0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = gmul(rc, 8'h02);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // Datapath: in counting mode every round adds one; otherwise one AES inverse-cipher round.
    function automatic logic [127:0] dp(input logic [127:0] s, input logic [1:0] rt,
                                        input logic [127:0] k, input logic aes);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [127:0] o;
        logic [7:0]   acc;
        if (!aes) return s + 128'd1;
        if (rt == 2'd0) return s ^ k;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = inv_sbox(a[r + 4*((c - r + 4) % 4)]);
        for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
        if (rt == 2'd1) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gmul(b[j+4*c], mcoef((j - r + 4) % 4));
                    a[r+4*c] = acc;
                end
            for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
        end else begin
            for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        end
        return o;
    endfunction

    assign round_key       = keymem(round_key_addr);
    assign round_new_block = dp(round_block, round_type, round_key, aes_mode);

    // ---------------- transaction-level reference model ----------------
    // A job is N+1 steps: step 0 is INIT, step N is FINAL, step k uses key address N-k.
    logic         m_busy;
    logic         m_valid;
    int           m_step;
    int           m_n;
    logic [127:0] m_blk;

    function automatic logic [1:0] exp_type(input int step, input int n);
        if (step == 0) return 2'd0;
        if (step == n) return 2'd2;
        return 2'd1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_step <= 0; m_n <= 0; m_blk <= 128'd0;
        end else if (abort && m_busy) begin
            m_busy <= 1'b0; m_valid <= 1'b0;
        end else if (!m_busy && next) begin
            m_busy <= 1'b1; m_valid <= 1'b0; m_step <= 0;
            m_n <= keylen ? 14 : 10; m_blk <= block;
        end else if (m_busy) begin
            m_blk <= dp(m_blk, exp_type(m_step, m_n), keymem(4'(m_n - m_step)), aes_mode);
            if (m_step == m_n) begin
                m_busy <= 1'b0; m_valid <= 1'b1;
            end else begin
                m_step <= m_step + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("ready", 128'(ready), 128'(!m_busy));
            chk("valid", 128'(valid), 128'(m_valid));
            chk("new_block", new_block, m_blk);
            chk("round_block", round_block, m_blk);
            chk("round_type", 128'(round_type), 128'(m_busy ? exp_type(m_step, m_n) : 2'd0));
            chk("round_key_addr", 128'(round_key_addr), 128'(m_busy ? 4'(m_n - m_step) : 4'd0));
        end
    end

    // Launch one block, optionally poke next while busy, and count edges until ready returns.
    task automatic run_op(input logic kl, input logic [127:0] b, input bit b2b, input int busy_at,
                          input bit chk_res, input logic [127:0] exp_res, input string nm);
        int cyc;
        int expc;
        expc = kl ? 15 : 11;
        if (!b2b) @(posedge clk);
        #1; next = 1'b1; keylen = kl; block = b;
        @(posedge clk); #1; next = 1'b0;
        cyc = 0;
        while (!ready && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            next = (cyc == busy_at);
            if (cyc == busy_at) begin
                keylen = ~kl; block = ~b;
            end
        end
        next = 1'b0;
        chk({nm, "_cycles"}, 128'(cyc), 128'(expc));
        chk({nm, "_valid_done"}, 128'(valid), 128'd1);
        if (chk_res) chk({nm, "_result"}, new_block, exp_res);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b1; next = 1'b0; keylen = 1'b0; abort = 1'b0; block = 128'd0; aes_mode = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_new_block", new_block, 128'd0);
        chk("rst_addr", 128'(round_key_addr), 128'd0);
        chk("rst_type", 128'(round_type), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(1'b0, 128'd0, 1'b0, 0, 1'b1, 128'h0B, "aes128_count");
        run_op(1'b1, 128'h100, 1'b0, 0, 1'b1, 128'h10F, "aes256_count");
        aes_mode = 1'b1;
        run_op(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 0, 1'b1,
               128'h00112233445566778899aabbccddeeff, "kat128");
        aes_mode = 1'b0;
        run_op(1'b0, 128'h5000, 1'b1, 4, 1'b1, 128'h500B, "busy_next_b2b");
        repeat (3) @(posedge clk);
        #1 chk("idle_valid_held", 128'(valid), 128'd1);

        // Asynchronous reset in the middle of the MAIN rounds.
        @(posedge clk); #1 next = 1'b1; keylen = 1'b0; block = 128'h77;
        @(posedge clk); #1 next = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("mid_addr", 128'(round_key_addr), 128'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("async_ready", 128'(ready), 128'd1);
        chk("async_valid", 128'(valid), 128'd0);
        chk("async_new_block", new_block, 128'd0);
        chk("async_addr", 128'(round_key_addr), 128'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_ready", 128'(ready), 128'd1);

`ifdef AES_DECIPHER_CTRL_ABORT_EN
        @(posedge clk); #1 next = 1'b1; keylen = 1'b0; block = 128'h900;
        @(posedge clk); #1 next = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_ready", 128'(ready), 128'd1);
        chk("abort_valid", 128'(valid), 128'd0);
        chk("abort_addr", 128'(round_key_addr), 128'd0);
        run_op(1'b0, 128'hA00, 1'b1, 0, 1'b1, 128'hA0B, "after_abort");
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("idle_abort_valid", 128'(valid), 128'd1);
        abort = 1'b1; next = 1'b1; keylen = 1'b0; block = 128'h20;
        @(posedge clk); #1 abort = 1'b0; next = 1'b0;
        chk("abort_next_accept", 128'(ready), 128'd0);
        cyc = 0;
        while (!ready && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        chk("abort_next_result", new_block, 128'h2B);
`endif

        for (int i = 0; i < 30; i++) begin
            logic         kl;
            logic [127:0] b;
            bit           b2b;
            int           ba;
            kl  = 1'($urandom % 2);
            b   = {$urandom, $urandom, $urandom, $urandom};
            b2b = 1'($urandom % 2);
            ba  = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 10));
            aes_mode = 1'($urandom % 2);
            if (!b2b) repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(kl, b, b2b, ba, 1'b0, 128'd0, "random");
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
